g_buf_elastic: RTL and testbench

G_BUF_ELASTIC -- requirements
Module: g_buf_elastic

---
 rtl/g_buf_elastic.sv | 84 ++++++++
 tb/tb_g_buf_elastic.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/g_buf_elastic.sv
// Elastic FIFO buffer: DEPTH-entry circular store with valid/ready on both sides,
// occupancy count, and a sticky overflow flag for writes attempted while full.
module g_buf_elastic #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A,
  input  logic             A_VLD,
  output logic             A_RDY,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VLD,
  input  logic             Y_RDY,
  output logic [AW:0]      CNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVF
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full_w, empty_w, push_w, pop_w;

  assign full_w  = (cnt_q == DEPTH_C);
  assign empty_w = (cnt_q == '0);
  // Handshakes depend only on registered occupancy, so no ready/valid feed-through.
  assign push_w  = A_VLD && !full_w;
  assign pop_w   = Y_RDY && !empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_w && !pop_w)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop_w && !push_w) cnt_d = cnt_q - (AW+1)'(1);
      if (A_VLD && full_w) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; RSTN gating keeps an edge held in reset from writing.
  always_ff @(posedge CLK) begin
    if (RSTN && push_w && !CLR) mem_q[wr_ptr_q] <= A;
  end

  assign A_RDY = !full_w;
  assign Y_VLD = !empty_w;
  assign Y     = empty_w ? '0 : mem_q[rd_ptr_q];
  assign CNT   = cnt_q;
  assign FULL  = full_w;
  assign EMPTY = empty_w;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_g_buf_elastic.sv
// Directed self-checking bench for g_buf_elastic at WIDTH=8, DEPTH=4.
module tb_g_buf_elastic;

  logic       clk, rstn, clr, a_vld, y_rdy;
  logic [7:0] a;
  logic       a_rdy, y_vld, full, empty, ovf;
  logic [7:0] y;
  logic [2:0] cnt;
  int checks, errors;

  g_buf_elastic #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(clk), .RSTN(rstn), .CLR(clr), .A(a), .A_VLD(a_vld), .A_RDY(a_rdy),
    .Y(y), .Y_VLD(y_vld), .Y_RDY(y_rdy), .CNT(cnt), .FULL(full),
    .EMPTY(empty), .OVF(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    a = d; a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; a = 8'h00; a_vld = 1'b0; y_rdy = 1'b0;
    #12;
    checks++;
    if (cnt !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || y_vld !== 1'b0 ||
        a_rdy !== 1'b1 || y !== 8'h00 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%0d empty=%b full=%b y_vld=%b a_rdy=%b y=%h ovf=%b (want 0 1 0 0 1 00 0)",
               cnt, empty, full, y_vld, a_rdy, y, ovf);
    end
    @(negedge clk); rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    y_rdy = 1'b0;
    push(8'hA5);
    checks++;
    if (y !== 8'hA5 || y_vld !== 1'b1 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_push: y=%h y_vld=%b cnt=%0d (want a5 1 1)", y, y_vld, cnt);
    end
    y_rdy = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1 || y !== 8'h00 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: empty=%b y=%h cnt=%0d (want 1 00 0)", empty, y, cnt);
    end
    tick();
    checks++;
    if (cnt !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: cnt=%0d empty=%b (want 0 1)", cnt, empty);
    end
    y_rdy = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] exp_v;
    for (int i = 1; i <= 4; i++) push(8'(i));
    checks++;
    if (full !== 1'b1 || a_rdy !== 1'b0 || cnt !== 3'd4 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b a_rdy=%b cnt=%0d ovf=%b (want 1 0 4 0)", full, a_rdy, cnt, ovf);
    end
    push(8'h05);
    checks++;
    if (ovf !== 1'b1 || cnt !== 3'd4 || y !== 8'h01) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d y=%h (want 1 4 01)", ovf, cnt, y);
    end
    // full with concurrent write and read: only the pop happens
    a = 8'h06; a_vld = 1'b1; y_rdy = 1'b1;
    tick();
    a_vld = 1'b0;
    checks++;
    if (cnt !== 3'd3 || ovf !== 1'b1 || y !== 8'h02 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_simul: cnt=%0d ovf=%b y=%h full=%b (want 3 1 02 0)", cnt, ovf, y, full);
    end
    for (int i = 2; i <= 4; i++) begin
      exp_v = 8'(i);
      checks++;
      if (y !== exp_v || y_vld !== 1'b1) begin
        errors++;
        $display("FAIL drain_order[%0d]: y=%h y_vld=%b (want %h 1)", i, y, y_vld, exp_v);
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: empty=%b ovf=%b (want 1 1)", empty, ovf);
    end
    y_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL clr_idle: ovf=%b cnt=%0d (want 0 0)", ovf, cnt);
    end
    push(8'd10);
    push(8'd11);
    a_vld = 1'b1; y_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 8'(12 + i);
      exp_v = 8'(10 + i);
      checks++;
      if (y !== exp_v || cnt !== 3'd2) begin
        errors++;
        $display("FAIL b2b[%0d]: y=%h cnt=%0d (want %h 2)", i, y, cnt, exp_v);
      end
      tick();
    end
    a_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_v = 8'(20 + i);
      checks++;
      if (y !== exp_v || cnt !== 3'(2 - i)) begin
        errors++;
        $display("FAIL b2b_tail[%0d]: y=%h cnt=%0d (want %h %0d)", i, y, cnt, exp_v, 2 - i);
      end
      tick();
    end
    y_rdy = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: empty=%b (want 1)", empty);
    end
  endtask

  task automatic test_clr();
    for (int i = 1; i <= 4; i++) push(8'(i));
    push(8'h55);
    y_rdy = 1'b1; tick(); y_rdy = 1'b0;
    checks++;
    if (cnt !== 3'd3 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: cnt=%0d ovf=%b (want 3 1)", cnt, ovf);
    end
    clr = 1'b1; a = 8'h77; a_vld = 1'b1; y_rdy = 1'b1;
    tick();
    clr = 1'b0; a_vld = 1'b0; y_rdy = 1'b0;
    checks++;
    if (cnt !== 3'd0 || empty !== 1'b1 || ovf !== 1'b0 || y !== 8'h00) begin
      errors++;
      $display("FAIL clr: cnt=%0d empty=%b ovf=%b y=%h (want 0 1 0 00)", cnt, empty, ovf, y);
    end
  endtask

  task automatic test_async_reset();
    push(8'h11);
    push(8'h22);
    checks++;
    if (cnt !== 3'd2 || y !== 8'h11) begin
      errors++;
      $display("FAIL arst_setup: cnt=%0d y=%h (want 2 11)", cnt, y);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (cnt !== 3'd0 || y_vld !== 1'b0 || y !== 8'h00 || a_rdy !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate: cnt=%0d y_vld=%b y=%h a_rdy=%b empty=%b (want 0 0 00 1 1)",
               cnt, y_vld, y, a_rdy, empty);
    end
    a = 8'h99; a_vld = 1'b1;
    tick();
    checks++;
    if (cnt !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL arst_hold: cnt=%0d empty=%b (want 0 1)", cnt, empty);
    end
    a_vld = 1'b0;
    #2 rstn = 1'b1;
    tick();
    push(8'h3C);
    checks++;
    if (y !== 8'h3C || y_vld !== 1'b1 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL arst_after: y=%h y_vld=%b cnt=%0d (want 3c 1 1)", y, y_vld, cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
